// File: rtl/uart_pkg.sv
// Shared UART types and constants: FSM state encoding, frame geometry and
// the bit-period divider used by the transmitter and its baud generator.
`timescale 1ns/1ps

package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   // Truncating division; callers must keep the result at 2 or more.
   function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit; clear holds it at 0 so every frame starts on a fresh bit period.
`timescale 1ns/1ps

module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic clk,
   input  logic resetn,
   input  logic clear,
   output logic bit_tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count <= '0;
      end else if (clear || bit_tick) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

   assign bit_tick = (count == LAST_COUNT);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 by default; defining UART_TX_PARITY_EN inserts an
// even-parity bit between the data bits and the stop bit (8E1).
`timescale 1ns/1ps

module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 9600
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       tx_enable,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   tx_state_t  state;
   tx_state_t  state_next;
   logic [7:0] shift_reg;
   logic [7:0] shift_next;
   logic [2:0] bit_idx;
   logic [2:0] idx_next;
   logic       tx_next;
   logic       busy_next;
   logic       done_next;
   logic       bit_tick;
   logic       baud_clear;

`ifdef UART_TX_PARITY_EN
   logic       parity_reg;
   logic       parity_next;
`endif

   // The counter sits at 0 while idle, so the accepting edge starts a full bit.
   assign baud_clear = (state == IDLE);

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_gen (
      .clk      (clk),
      .resetn   (resetn),
      .clear    (baud_clear),
      .bit_tick (bit_tick)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         shift_reg <= '0;
         bit_idx   <= '0;
         tx        <= 1'b1;
         tx_busy   <= 1'b0;
         tx_done   <= 1'b0;
      end else begin
         state     <= state_next;
         shift_reg <= shift_next;
         bit_idx   <= idx_next;
         tx        <= tx_next;
         tx_busy   <= busy_next;
         tx_done   <= done_next;
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         parity_reg <= 1'b0;
      end else begin
         parity_reg <= parity_next;
      end
   end
`endif

   // Outputs are registered from the next-state values, so tx, tx_busy and
   // tx_done change on the same edge as the state they describe.
   always_comb begin
      state_next = state;
      shift_next = shift_reg;
      idx_next   = bit_idx;
      tx_next    = tx;
      busy_next  = tx_busy;
      done_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_next = parity_reg;
`endif

      case (state)
         IDLE: begin
            tx_next   = 1'b1;
            busy_next = 1'b0;
            if (tx_start && tx_enable) begin
               state_next = START;
               shift_next = tx_data;
               idx_next   = '0;
               tx_next    = 1'b0;
               busy_next  = 1'b1;
`ifdef UART_TX_PARITY_EN
               parity_next = ^tx_data;
`endif
            end
         end

         START: begin
            if (bit_tick) begin
               state_next = DATA;
               tx_next    = shift_reg[0];
            end
         end

         DATA: begin
            if (bit_tick) begin
               if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                  state_next = PARITY;
                  tx_next    = parity_reg;
`else
                  state_next = STOP;
                  tx_next    = 1'b1;
`endif
               end else begin
                  // Bit 0 of the shift register is always the bit on the line.
                  idx_next   = bit_idx + 3'd1;
                  shift_next = {1'b0, shift_reg[7:1]};
                  tx_next    = shift_reg[1];
               end
            end
         end

`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_tick) begin
               state_next = STOP;
               tx_next    = 1'b1;
            end
         end
`endif

         STOP: begin
            if (bit_tick) begin
               state_next = IDLE;
               tx_next    = 1'b1;
               busy_next  = 1'b0;
               done_next  = 1'b1;
            end
         end

         default: begin
            state_next = IDLE;
            tx_next    = 1'b1;
            busy_next  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: directed and random frames, scoreboard of expected
// bytes popped by a line monitor that reconstructs each frame from the tx pin.
`timescale 1ns/1ps

module tb_uart_tx;

   localparam int CLK_FREQ  = 1050;
   localparam int BAUD_RATE = 100;
   localparam int CPB       = CLK_FREQ / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME_CYC = NB * CPB;

   logic       clk = 1'b0;
   logic       resetn = 1'b1;
   logic       tx_enable = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_start = 1'b0;
   logic       tx;
   logic       tx_busy;
   logic       tx_done;

   logic [7:0] exp_q[$];
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_tx #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD_RATE)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .tx_enable (tx_enable),
      .tx_data   (tx_data),
      .tx_start  (tx_start),
      .tx        (tx),
      .tx_busy   (tx_busy),
      .tx_done   (tx_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference frame: start 0, data LSB first, optional even parity, stop 1.
   function automatic logic [NB-1:0] frame_bits(input logic [7:0] d);
      logic [NB-1:0] f;
      f = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
      f[9] = ^d;
`endif
      f[NB-1] = 1'b1;
      return f;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic send(input logic [7:0] d, input logic en, input logic expect_frame);
      @(negedge clk);
      tx_data   = d;
      tx_enable = en;
      tx_start  = 1'b1;
      if (expect_frame) exp_q.push_back(d);
      @(negedge clk);
      tx_start = 1'b0;
      tx_data  = 8'($urandom);
   endtask

   task automatic back_to_back(input logic [7:0] d);
      tx_data   = d;
      tx_enable = 1'b1;
      tx_start  = 1'b1;
      exp_q.push_back(d);
      @(negedge clk);
      check("b2b_tx", tx, 0);
      check("b2b_busy", tx_busy, 1);
      tx_start = 1'b0;
      tx_data  = 8'($urandom);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 3 * FRAME_CYC; i++) begin
         @(negedge clk);
         if (tx_busy === 1'b0) break;
      end
      check("wait_idle", tx_busy, 0);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 3 * FRAME_CYC; i++) begin
         if (tx_done === 1'b1) break;
         @(negedge clk);
      end
      check("wait_done", tx_done, 1);
   endtask

   task automatic check_disabled();
      for (int i = 0; i < CPB; i++) begin
         check("disabled_busy", tx_busy, 0);
         check("disabled_tx", tx, 1);
         @(negedge clk);
      end
   endtask

   // ---------------- monitor ----------------
   task automatic run_frame();
      logic [7:0]    d;
      logic [NB-1:0] fb;
      logic [NB-1:0] mid;
      int wrong = 0;
      int busy_low = 0;
      int done_hi = 0;
      bit aborted = 0;
      check("frame_expected", 32'(exp_q.size() != 0), 1);
      d   = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
      fb  = frame_bits(d);
      mid = '0;
      for (int c = 0; c < FRAME_CYC; c++) begin
         if (c > 0) @(negedge clk);
         if (!resetn) begin
            aborted = 1;
            break;
         end
         if (c % CPB == CPB / 2) mid[c/CPB] = tx;
         if (tx !== fb[c/CPB]) wrong++;
         if (tx_busy !== 1'b1) busy_low++;
         if (tx_done !== 1'b0) done_hi++;
      end
      if (!aborted) begin
         for (int i = 0; i < NB; i++)
            check($sformatf("frame_%02h_bit%0d", d, i), mid[i], fb[i]);
         check("bit_hold_cycles_wrong", wrong, 0);
         check("busy_low_in_frame", busy_low, 0);
         check("done_in_frame", done_hi, 0);
         @(negedge clk);
         if (resetn) begin
            check("end_done", tx_done, 1);
            check("end_busy", tx_busy, 0);
            check("end_tx", tx, 1);
         end
      end
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (!resetn) begin
            check("in_reset_tx", tx, 1);
            check("in_reset_busy", tx_busy, 0);
            check("in_reset_done", tx_done, 0);
         end else if (tx === 1'b0) begin
            run_frame();
         end else begin
            check("idle_busy", tx_busy, 0);
            check("idle_done", tx_done, 0);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin : stim
      logic [7:0] d;
      #1 resetn = 1'b0;
      #20;
      check("reset_tx_a", tx, 1); check("reset_busy_a", tx_busy, 0); check("reset_done_a", tx_done, 0);
      #40;
      check("reset_tx_b", tx, 1); check("reset_busy_b", tx_busy, 0); check("reset_done_b", tx_done, 0);
      #39;
      check("reset_tx_c", tx, 1); check("reset_busy_c", tx_busy, 0); check("reset_done_c", tx_done, 0);
      @(negedge clk);
      resetn = 1'b1;
      repeat (3) @(negedge clk);

      send(8'h82, 1'b1, 1'b1);
      check("accept_busy", tx_busy, 1);
      check("accept_tx", tx, 0);
      wait_idle();

      repeat (2000) @(negedge clk);
      send(8'h5A, 1'b1, 1'b1);
      repeat (25) @(negedge clk);
      send(8'h00, 1'b1, 1'b0);
      wait_done();
      back_to_back(8'hFF);
      wait_idle();

      repeat (5) @(negedge clk);
      send(8'h33, 1'b0, 1'b0);
      check_disabled();

      send(8'hC3, 1'b1, 1'b1);
      repeat (3 * CPB) @(negedge clk);
      tx_enable = 1'b0;
      wait_idle();

      send(8'hA7, 1'b1, 1'b1);
      repeat (4 * CPB + CPB / 2) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      check("midreset_tx", tx, 1);
      check("midreset_busy", tx_busy, 0);
      check("midreset_done", tx_done, 0);
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      send(8'h41, 1'b1, 1'b1);
      wait_idle();

      for (int n = 0; n < 30; n++) begin
         d = 8'($urandom_range(0, 255));
         send(d, 1'b1, 1'b1);
         case ($urandom_range(0, 3))
            0: begin
               repeat ($urandom_range(1, FRAME_CYC - 4)) @(negedge clk);
               send(8'($urandom), 1'b1, 1'b0);
               wait_idle();
            end
            1: begin
               wait_idle();
               repeat ($urandom_range(0, 20)) @(negedge clk);
            end
            2: begin
               wait_done();
               back_to_back(8'($urandom));
               wait_idle();
            end
            default: begin
               wait_idle();
               send(8'($urandom), 1'b0, 1'b0);
               check_disabled();
            end
         endcase
      end

      for (int i = 0; i < 3 * FRAME_CYC; i++) begin
         if (exp_q.size() == 0 && tx_busy === 1'b0) break;
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
      check("drain_queue", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #500_000;
      checks++;
      failures++;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
